// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the CPU pipeline stage register.
//   ctrl_bundle_t  : packed control bundle carried between stages (12 bits)
//   PIPE_CTRL_W    : width of the control bundle
//   PIPE_DATA_W    : default width of the data payload
//   PIPE_CTRL_BUBBLE : control value that performs no architectural write
//   stage_state_t  : occupancy state of a stage (EMPTY / ONE / FULL)
//   occ_of()       : number of held entries for a given state
// ----------------------------------------------------------------------------
package pipe_pkg;

  localparam int ALU_CTRL_W = 4;
  localparam int MEM_SIZE_W = 2;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  status_bit;
    logic [MEM_SIZE_W-1:0] mem_size;
  } ctrl_bundle_t;

  localparam int PIPE_CTRL_W = $bits(ctrl_bundle_t);
  localparam int PIPE_DATA_W = 96;

  // All enables low: a bubble can never write a register or memory.
  localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  function automatic logic [1:0] occ_of(input stage_state_t s);
    case (s)
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// ----------------------------------------------------------------------------
// pipe_slot
// One storage entry of a pipeline stage: valid flag plus control/data payload.
//   clk, reset_n     : clock (rising edge), asynchronous active-low reset
//   i_load           : capture i_ctrl/i_data and set valid (wins over clear)
//   i_clear          : drop the valid flag (payload retained, it is don't-care)
//   i_ctrl, i_data   : payload to capture
//   o_valid, o_ctrl, o_data : held entry
// ----------------------------------------------------------------------------
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
// Pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready
// handshake, optional skid entry, stall and flush. out_ctrl is forced to
// CTRL_BUBBLE whenever the stage holds nothing.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake (in_ready registered if SKID=1)
//   in_ctrl, in_data      : upstream control bundle and payload
//   stall                 : freeze everything (no accept, no release)
//   flush                 : discard all held entries; has priority over stall
//   out_valid/out_ready   : downstream handshake
//   out_ctrl, out_data    : to next stage
//   occupancy             : held entries, 0..2
// ----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = PIPE_CTRL_W,
  parameter int                DATA_W      = PIPE_DATA_W,
  parameter bit                SKID        = 1'b1,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = PIPE_CTRL_BUBBLE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  stage_state_t r_state;
  stage_state_t w_state_next;
  logic [1:0]   r_occupancy;

  logic w_in_ready;
  logic w_in_xfer;
  logic w_out_xfer;

  logic w_main_load, w_main_clear, w_main_from_skid;
  logic w_skid_load, w_skid_clear;

  logic              w_main_valid;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl_in;
  logic [DATA_W-1:0] w_main_data_in;

  logic              w_skid_valid;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  assign w_in_xfer  = in_valid & w_in_ready;
  assign w_out_xfer = w_main_valid & out_ready & ~stall;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_occupancy <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_occupancy <= occ_of(w_state_next);
    end
  end

  // Next-state logic: flush > stall > normal handshake
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = EMPTY;
    end else if (!stall) begin
      case (r_state)
        EMPTY: if (w_in_xfer) w_state_next = ONE;
        ONE: begin
          if (w_in_xfer && !w_out_xfer) w_state_next = SKID ? FULL : ONE;
          else if (!w_in_xfer && w_out_xfer) w_state_next = EMPTY;
        end
        FULL: if (w_out_xfer) w_state_next = ONE;
        default: w_state_next = EMPTY;
      endcase
    end
  end

  // Slot control outputs
  always_comb begin
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else if (!stall) begin
      case (r_state)
        EMPTY: w_main_load = w_in_xfer;
        ONE: begin
          if (w_in_xfer && w_out_xfer) w_main_load = 1'b1;
          else if (w_in_xfer)          w_skid_load = 1'b1;
          else if (w_out_xfer)         w_main_clear = 1'b1;
        end
        FULL: begin
          // Skid entry slides forward; FULL never accepts input.
          if (w_out_xfer) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
          end
        end
        default: begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_in = w_main_from_skid ? w_skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_ctrl  (w_main_ctrl_in),
    .i_data  (w_main_data_in),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  generate
    if (SKID) begin : g_skid
      logic r_in_ready;

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
      );

      // Registered from the next state so in_ready never follows out_ready
      // combinationally; stall/flush only gate it off.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_in_ready <= 1'b1;
        else          r_in_ready <= (w_state_next != FULL);
      end

      assign w_in_ready = r_in_ready & ~stall & ~flush;
    end else begin : g_noskid
      assign w_skid_valid = 1'b0;
      assign w_skid_ctrl  = '0;
      assign w_skid_data  = '0;
      // Single entry: accept when empty or when the held word leaves now.
      assign w_in_ready   = ~stall & ~flush & (~w_main_valid | out_ready);
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = w_main_valid;
  assign out_ctrl  = w_main_valid ? w_main_ctrl : CTRL_BUBBLE;
  assign out_data  = w_main_data;
  assign occupancy = r_occupancy;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic clk;
  logic reset_n;

  // SKID=1 instance
  logic        iv1, st1, fl1, or1, ir1, ov1;
  logic [11:0] ic1, oc1;
  logic [95:0] id1, od1;
  logic [1:0]  oq1;
  // SKID=0 instance
  logic        iv0, st0, fl0, or0, ir0, ov0;
  logic [11:0] ic0, oc0;
  logic [95:0] id0, od0;
  logic [1:0]  oq0;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.CTRL_W(12), .DATA_W(96), .SKID(1'b1), .CTRL_BUBBLE(12'h000)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv1), .in_ready(ir1), .in_ctrl(ic1), .in_data(id1),
    .stall(st1), .flush(fl1),
    .out_valid(ov1), .out_ready(or1), .out_ctrl(oc1), .out_data(od1),
    .occupancy(oq1)
  );

  pipe_stage_reg #(.CTRL_W(12), .DATA_W(96), .SKID(1'b0), .CTRL_BUBBLE(12'h000)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv0), .in_ready(ir0), .in_ctrl(ic0), .in_data(id0),
    .stall(st0), .flush(fl0),
    .out_valid(ov0), .out_ready(or0), .out_ctrl(oc0), .out_data(od0),
    .occupancy(oq0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] data_of(input logic [11:0] c);
    return {c, 4'hA, c, 4'hB, c, 4'hC, c, 4'hD, 20'hDEAD0, c};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then settle.
  task automatic s1(input logic iv, input logic [11:0] c, input logic orr,
                    input logic st, input logic fl);
    @(negedge clk);
    iv1 = iv; ic1 = c; id1 = data_of(c); or1 = orr; st1 = st; fl1 = fl;
    #1;
  endtask

  task automatic s0(input logic iv, input logic [11:0] c, input logic orr,
                    input logic st, input logic fl);
    @(negedge clk);
    iv0 = iv; ic0 = c; id0 = data_of(c); or0 = orr; st0 = st; fl0 = fl;
    #1;
  endtask

  initial begin
    iv1 = 0; ic1 = 0; id1 = 0; or1 = 0; st1 = 0; fl1 = 0;
    iv0 = 0; ic0 = 0; id0 = 0; or0 = 0; st0 = 0; fl0 = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;

    // ---------------- reset state ----------------
    @(negedge clk); #1;
    chk("rst1_ov",  ov1, 0);
    chk("rst1_oc",  oc1, 0);
    chk("rst1_od",  od1, 0);
    chk("rst1_occ", oq1, 0);
    chk("rst1_ir",  ir1, 1);
    chk("rst0_ov",  ov0, 0);
    chk("rst0_occ", oq0, 0);
    chk("rst0_ir",  ir0, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- SKID=1 streaming ----------------
    for (int i = 1; i <= 8; i++) begin
      s1(1, 12'(i), 1, 0, 0);
      chk("s1_stream_ir", ir1, 1);
      if (i > 1) begin
        chk("s1_stream_ov", ov1, 1);
        chk("s1_stream_oc", oc1, i - 1);
        chk("s1_stream_occ", oq1, 1);
      end
    end
    s1(0, 0, 1, 0, 0);
    chk("s1_stream_last", oc1, 8);
    chk("s1_stream_last_od", od1, data_of(12'd8));
    s1(0, 0, 1, 0, 0);
    chk("s1_stream_drain_ov", ov1, 0);
    chk("s1_stream_drain_oc", oc1, 0);
    chk("s1_stream_drain_occ", oq1, 0);

    // ---------------- SKID=1 backpressure ----------------
    s1(1, 12'h0A1, 0, 0, 0);
    chk("s1_bp_a_ir", ir1, 1);
    s1(1, 12'h0B2, 0, 0, 0);
    chk("s1_bp_b_ir", ir1, 1);
    chk("s1_bp_b_oc", oc1, 12'h0A1);
    s1(1, 12'h0C3, 0, 0, 0);
    chk("s1_bp_full_ir", ir1, 0);
    chk("s1_bp_full_oc", oc1, 12'h0A1);
    chk("s1_bp_full_occ", oq1, 2);
    s1(1, 12'h0C3, 1, 0, 0);
    chk("s1_bp_rel_ir", ir1, 0);
    chk("s1_bp_rel_oc", oc1, 12'h0A1);
    chk("s1_bp_rel_od", od1, data_of(12'h0A1));
    s1(1, 12'h0C3, 1, 0, 0);
    chk("s1_bp_b_out", oc1, 12'h0B2);
    chk("s1_bp_b_out_od", od1, data_of(12'h0B2));
    chk("s1_bp_b_out_ir", ir1, 1);
    chk("s1_bp_b_out_occ", oq1, 1);
    s1(0, 0, 1, 0, 0);
    chk("s1_bp_c_out", oc1, 12'h0C3);
    chk("s1_bp_c_out_ov", ov1, 1);
    s1(0, 0, 1, 0, 0);
    chk("s1_bp_empty_ov", ov1, 0);
    chk("s1_bp_empty_occ", oq1, 0);

    // ---------------- SKID=1 stall ----------------
    s1(1, 12'h011, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      s1(1, 12'h012, 1, 1, 0);
      chk("s1_stall_ir", ir1, 0);
      chk("s1_stall_ov", ov1, 1);
      chk("s1_stall_oc", oc1, 12'h011);
      chk("s1_stall_occ", oq1, 1);
    end
    s1(1, 12'h012, 1, 0, 0);
    chk("s1_unstall_ir", ir1, 1);
    chk("s1_unstall_oc", oc1, 12'h011);
    s1(0, 0, 1, 0, 0);
    chk("s1_unstall_next", oc1, 12'h012);
    s1(0, 0, 1, 0, 0);
    chk("s1_unstall_empty", ov1, 0);

    // ---------------- SKID=1 flush while FULL ----------------
    s1(1, 12'h021, 0, 0, 0);
    s1(1, 12'h022, 0, 0, 0);
    s1(1, 12'hFFF, 0, 0, 1);
    chk("s1_flush_ir", ir1, 0);
    chk("s1_flush_occ_before", oq1, 2);
    chk("s1_flush_ov_before", ov1, 1);
    s1(0, 0, 1, 0, 0);
    chk("s1_flush_occ", oq1, 0);
    chk("s1_flush_ov", ov1, 0);
    chk("s1_flush_oc", oc1, 0);
    chk("s1_flush_ir_after", ir1, 1);
    s1(0, 0, 1, 0, 0);
    chk("s1_flush_no_fff", ov1, 0);

    // ---------------- SKID=1 flush + stall together ----------------
    s1(1, 12'h031, 0, 0, 0);
    s1(1, 12'h032, 0, 1, 1);
    chk("s1_fs_ir", ir1, 0);
    chk("s1_fs_oc_before", oc1, 12'h031);
    s1(0, 0, 0, 0, 0);
    chk("s1_fs_ov", ov1, 0);
    chk("s1_fs_occ", oq1, 0);

    // ---------------- mid-stream reset with 2 entries ----------------
    s1(1, 12'h041, 0, 0, 0);
    s1(1, 12'h042, 0, 0, 0);
    s1(0, 0, 0, 0, 0);
    chk("s1_prerst_occ", oq1, 2);
    reset_n = 1'b0;
    #1;
    chk("s1_midrst_ov", ov1, 0);
    chk("s1_midrst_oc", oc1, 0);
    chk("s1_midrst_occ", oq1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("s1_postrst_ir", ir1, 1);
    s1(0, 0, 1, 0, 0);
    chk("s1_postrst_ov", ov1, 0);

    // ---------------- SKID=0 streaming ----------------
    for (int i = 1; i <= 8; i++) begin
      s0(1, 12'(i), 1, 0, 0);
      chk("s0_stream_ir", ir0, 1);
      if (i > 1) begin
        chk("s0_stream_oc", oc0, i - 1);
        chk("s0_stream_occ", oq0, 1);
      end
    end
    s0(0, 0, 1, 0, 0);
    chk("s0_stream_last", oc0, 8);
    s0(0, 0, 1, 0, 0);
    chk("s0_stream_drain_ov", ov0, 0);

    // ---------------- SKID=0 backpressure ----------------
    s0(1, 12'h0A1, 0, 0, 0);
    chk("s0_bp_a_ir", ir0, 1);
    s0(1, 12'h0B2, 0, 0, 0);
    chk("s0_bp_block_ir", ir0, 0);
    chk("s0_bp_block_oc", oc0, 12'h0A1);
    chk("s0_bp_block_occ", oq0, 1);
    s0(1, 12'h0B2, 1, 0, 0);
    chk("s0_bp_comb_ir", ir0, 1);
    chk("s0_bp_comb_oc", oc0, 12'h0A1);
    s0(0, 0, 1, 0, 0);
    chk("s0_bp_b_out", oc0, 12'h0B2);
    chk("s0_bp_b_out_od", od0, data_of(12'h0B2));
    chk("s0_bp_b_out_occ", oq0, 1);
    s0(0, 0, 1, 0, 0);
    chk("s0_bp_empty", ov0, 0);

    // ---------------- SKID=0 stall and flush ----------------
    s0(1, 12'h051, 1, 0, 0);
    s0(1, 12'h052, 1, 1, 0);
    chk("s0_stall_ir", ir0, 0);
    chk("s0_stall_oc", oc0, 12'h051);
    s0(1, 12'h052, 1, 0, 0);
    chk("s0_unstall_oc", oc0, 12'h051);
    chk("s0_unstall_ir", ir0, 1);
    s0(1, 12'hFFF, 1, 0, 1);
    chk("s0_flush_ir", ir0, 0);
    chk("s0_flush_oc_before", oc0, 12'h052);
    s0(0, 0, 1, 0, 0);
    chk("s0_flush_ov", ov0, 0);
    chk("s0_flush_oc", oc0, 0);
    chk("s0_flush_occ", oq0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
